chunk_adder_seq: RTL and testbench
==================================

CHUNK_ADDER_SEQ -- requirements
Module: chunk_adder_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 SHALL derive NCHUNK = WIDTH/CHUNK; WIDTH SHALL be a positive multiple of CHUNK, and any other value SHALL be a compile-time error.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operands and mode are valid.
REQ-008 in_ready  output  1  block can accept an operation.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-012 sub  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 s  output  WIDTH  sum or difference.
REQ-016 cout  output  1  carry-out (add); in subtract mode, 1 = no borrow.
REQ-017 ovf  output  1  two's-complement signed overflow.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 Accept SHALL occur on an edge with state IDLE and in_valid=1; the block SHALL latch a, b XOR {WIDTH{sub}}, and carry = cin XOR sub, clear the chunk index, and go to RUN.
REQ-021 in_valid SHALL be ignored in RUN and DONE; a, b, cin and sub SHALL be ignored after accept.
REQ-022 On each RUN edge, the block SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the latched operands plus the stored carry, write that chunk of s, store the new carry, and increment k.
REQ-023 On the edge processing k = NCHUNK-1, the block SHALL load cout with the final carry, set ovf = (carry into MSB) XOR (carry out of MSB), and go to DONE.
REQ-024 Latency: out_valid SHALL first be 1 exactly NCHUNK cycles after the accept edge; with NCHUNK=1, this is the next cycle.
REQ-025 In DONE, s, cout and ovf SHALL be held stable while out_ready=0.
REQ-026 On an edge with state DONE and out_ready=1, the block SHALL go to IDLE; in_ready SHALL be 1 in the following cycle, and s, cout and ovf SHALL hold their last values.
REQ-027 Subtract SHALL compute a - b - cin modulo 2^WIDTH.
REQ-028 Both add and subtract SHALL wrap modulo 2^WIDTH with no saturation.
REQ-029 s SHALL never expose partially computed chunks while out_valid=1.

Reset
REQ-030 rst=1 on any edge SHALL force IDLE with chunk index 0 and internal carry 0.
REQ-031 rst=1 on any edge SHALL clear s, cout, ovf and out_valid to 0 and set in_ready to 1 in the next cycle.
REQ-032 rst SHALL take priority over accept and out_ready.
REQ-033 rst asserted mid-RUN or in DONE SHALL abort the operation with no output of it produced.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Add 0xFFFF + 0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; out_valid is 1 exactly 4 cycles after accept.
REQ-035 Add 0x7FFF + 0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; add 0x1234 + 0x4321, cin=1 -> s=0x5556, cout=0, ovf=0.
REQ-036 Subtract 0x0005 - 0x0003, cin=0 -> s=0x0002, cout=1; subtract 0x0003 - 0x0005 -> s=0xFFFE, cout=0; subtract 0x8000 - 0x0001 -> s=0x7FFF, ovf=1.
REQ-037 Hold out_ready=0 for 3 cycles in DONE -> out_valid=1 and s/cout/ovf stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 Change a, b and sub and toggle in_valid during RUN -> result matches the originally latched operands; no second operation is accepted.
REQ-039 Assert rst in the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, s=0x0000; a following operation then completes correctly.

Source files
------------

// File: rtl/chunk_adder_seq.sv
// chunk_adder_seq: multi-cycle adder/subtractor that handles CHUNK bits per clock.
// An operation is latched in IDLE, processed LSB-chunk first in RUN, and
// presented in DONE until the consumer takes it with out_ready.
module chunk_adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Reject parameter sets that cannot be split into whole chunks.
  generate
    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunk_adder_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;        // latched operand A
  logic [WIDTH-1:0] r_b;        // latched operand B, already inverted for subtract
  logic             r_carry;    // carry between chunks
  logic [KW-1:0]    r_k;        // index of the chunk processed on the next RUN edge
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_carry_into_msb;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_k == K_LAST);

  // Chunk slice and its ripple sum; the top bit of w_sum is the chunk carry-out.
  assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out of it.
  assign w_carry_into_msb = w_sum[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update from
    // the same pre-edge values, regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nxt and no latch
    // is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then add one chunk per RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: r_a and r_b are deliberately left out of reset; they are always
      // loaded on accept before anything reads them.
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= cin ^ sub;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_s[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry <= w_sum[CHUNK];
      r_k     <= r_k + 1'b1;
      if (w_last) begin
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_carry_into_msb ^ w_sum[CHUNK];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Testbench for chunk_adder_seq (WIDTH=16, CHUNK=4): directed corner cases,
// handshake/hold behaviour, reset abort and randomized operations against a
// signed/unsigned integer reference model.
module tb_chunk_adder_seq;

  localparam int WIDTH    = 16;
  localparam int CHUNK    = 4;
  localparam int NCHUNK   = WIDTH / CHUNK;
  localparam int MAX_WAIT = 20;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  chunk_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then derive wrap, carry and overflow.
  function automatic result_t ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                        input logic rcin, input logic rsub);
    result_t r;
    longint  ua, ub, sa, sb, ci, exact_u, exact_s;
    ua = longint'(ra);
    ub = longint'(rb);
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ci = longint'(rcin);
    if (!rsub) begin
      exact_u = ua + ub + ci;
      exact_s = sa + sb + ci;
      r.cout  = (exact_u >= 65536);
    end else begin
      exact_u = ua - ub - ci;
      exact_s = sa - sb - ci;
      r.cout  = (exact_u >= 0);
    end
    r.s   = exact_u[WIDTH-1:0];
    r.ovf = (exact_s > 32767) || (exact_s < -32768);
    return r;
  endfunction

  // One full operation: accept, latency, result, optional hold, release.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic tcin, input logic tsub, input result_t exp,
                        input int hold, input bit scramble, input string tag);
    int lat;
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready); n_errors++;
    end
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL %s in_ready_in_run: got %b want 0 (cycle %0d)", tag, in_ready, lat); n_errors++;
      end
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        sub = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || lat != NCHUNK) begin
      $display("FAIL %s latency: got %0d cycles (out_valid=%b) want %0d", tag, lat, out_valid, NCHUNK);
      n_errors++;
    end
    n_checks++;
    if (s !== exp.s || cout !== exp.cout || ovf !== exp.ovf || in_ready !== 1'b0) begin
      $display("FAIL %s result: got s=%h cout=%b ovf=%b in_ready=%b want s=%h cout=%b ovf=%b in_ready=0",
               tag, s, cout, ovf, in_ready, exp.s, exp.cout, exp.ovf);
      n_errors++;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== exp.s || cout !== exp.cout || ovf !== exp.ovf) begin
        $display("FAIL %s hold%0d: got out_valid=%b in_ready=%b s=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 tag, i, out_valid, in_ready, s, cout, ovf, exp.s, exp.cout, exp.ovf);
        n_errors++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== exp.s || cout !== exp.cout || ovf !== exp.ovf) begin
      $display("FAIL %s release: got in_ready=%b out_valid=%b s=%h cout=%b ovf=%b want 1 0 %h %b %b",
               tag, in_ready, out_valid, s, cout, ovf, exp.s, exp.cout, exp.ovf);
      n_errors++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL %s idle_after_release: got in_ready=%b out_valid=%b want 1 0", tag, in_ready, out_valid);
      n_errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL reset_state: got in_ready=%b out_valid=%b s=%h cout=%b ovf=%b want 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ovf);
      n_errors++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0, 1'b0, "add_ffff_1");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 0, 1'b0, "add_7fff_1");
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}, 0, 1'b0, "add_1234_4321_c1");
  endtask

  task automatic test_sub();
    run_op(16'h0005, 16'h0003, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0}, 0, 1'b0, "sub_5_3");
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 0, 1'b0, "sub_3_5");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, 0, 1'b0, "sub_8000_1");
  endtask

  task automatic test_hold();
    run_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, ref_model(16'hA5A5, 16'h1234, 1'b1, 1'b0), 3, 1'b0, "hold3");
  endtask

  task automatic test_ignore_inputs();
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, ref_model(16'h0F0F, 16'h00F1, 1'b0, 1'b0), 1, 1'b1, "scramble_add");
    run_op(16'h1000, 16'h2001, 1'b1, 1'b1, ref_model(16'h1000, 16'h2001, 1'b1, 1'b1), 1, 1'b1, "scramble_sub");
  endtask

  task automatic test_reset_abort();
    // Abort in the second RUN cycle.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL reset_mid_run: got in_ready=%b out_valid=%b s=%h cout=%b ovf=%b want 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ovf);
      n_errors++;
    end
    for (int i = 0; i < NCHUNK + 1; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL reset_mid_run_no_output%0d: got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
        n_errors++;
      end
    end
    run_op(16'hBEEF, 16'h1234, 1'b0, 1'b1, ref_model(16'hBEEF, 16'h1234, 1'b0, 1'b1), 0, 1'b0, "after_reset_run");

    // Abort while a result is waiting in DONE.
    a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (NCHUNK) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL reset_done_setup: got out_valid=%b want 1", out_valid); n_errors++;
    end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL reset_in_done: got in_ready=%b out_valid=%b s=%h cout=%b ovf=%b want 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ovf);
      n_errors++;
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    int               hold;
    bit               scr;
    for (int n = 0; n < 40; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom);
      rs   = 1'($urandom);
      hold = int'($urandom_range(0, 3));
      scr  = 1'($urandom);
      if (n % 8 == 0) ra = {ra[15], {15{~ra[15]}}};
      run_op(ra, rb, rc, rs, ref_model(ra, rb, rc, rs), hold, scr, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_ignore_inputs();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
